// File: rtl/router_pkg.sv
// Shared definitions for the router controller: FSM encoding, header field layout, defaults.
package router_pkg;

    typedef enum logic [2:0] {
        DECODE,
        WAIT_TILL_EMPTY,
        LOAD_FIRST,
        LOAD_DATA,
        LOAD_PARITY,
        CHECK_PARITY
    } state_t;

    localparam logic [1:0] INVALID_ADDR    = 2'b11;
    localparam int         DEFAULT_TIMEOUT = 30;

    // Header byte: [1:0] destination port, [7:2] payload length
    localparam int ADDR_LSB = 0;
    localparam int ADDR_MSB = 1;
    localparam int LEN_LSB  = 2;
    localparam int LEN_MSB  = 7;
    localparam int LEN_W    = LEN_MSB - LEN_LSB + 1;

endpackage

// File: rtl/router_sync_timer.sv
// Per-port idle-read watchdog: pulses soft_reset for one cycle after TIMEOUT
// consecutive cycles of valid output data that nobody reads.
module router_sync_timer
    import router_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clock,
    input  logic resetn,
    input  logic vld,
    input  logic read_enb,
    output logic soft_reset
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count      <= '0;
            soft_reset <= 1'b0;
        end else begin
            soft_reset <= 1'b0;
            if (!vld || read_enb) begin
                count <= '0;
            end else if (count == CNT_W'(TIMEOUT - 1)) begin
                count      <= '0;
                soft_reset <= 1'b1;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/router_ctrl.sv
// Router packet-steering controller: decodes headers, sequences FIFO writes, per-port watchdogs.
// Optional build macro ROUTER_PARITY_CHK_EN enables the parity check and the err flag.
module router_ctrl
    import router_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       pkt_valid,
    input  logic [7:0] data_in,
    input  logic [2:0] fifo_full,
    input  logic [2:0] fifo_empty,
    input  logic [2:0] read_enb,
    output logic       busy,
    output logic [2:0] write_enb,
    output logic [7:0] dout,
    output logic       lfd_state,
    output logic [2:0] vld_out,
    output logic [2:0] soft_reset,
    output logic       err
);

    state_t           state, state_nxt;
    logic [7:0]       header;
    logic [1:0]       addr;
    logic [LEN_W-1:0] remaining;
    logic             rst_meta, rst_sync;
    logic             accept, abort, hdr_take, pay_take;

    // Reset asserts immediately but releases on a clock edge
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rst_meta <= 1'b0;
            rst_sync <= 1'b0;
        end else begin
            rst_meta <= 1'b1;
            rst_sync <= rst_meta;
        end
    end

    assign vld_out  = ~fifo_empty;
    assign accept   = pkt_valid && !busy;
    assign abort    = soft_reset[addr] && (state != DECODE) && (state != CHECK_PARITY);
    assign hdr_take = (state == DECODE) && pkt_valid &&
                      (data_in[ADDR_MSB:ADDR_LSB] != INVALID_ADDR);
    assign pay_take = (state == LOAD_DATA) && accept;

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        write_enb = '0;
        dout      = '0;
        lfd_state = 1'b0;
        case (state)
            DECODE: begin
                if (hdr_take)
                    state_nxt = fifo_empty[data_in[ADDR_MSB:ADDR_LSB]] ? LOAD_FIRST : WAIT_TILL_EMPTY;
            end
            WAIT_TILL_EMPTY: begin
                busy = 1'b1;
                if (fifo_empty[addr])
                    state_nxt = LOAD_FIRST;
            end
            LOAD_FIRST: begin
                busy      = 1'b1;
                lfd_state = 1'b1;
                dout      = header;
                write_enb = 3'b001 << addr;
                state_nxt = (header[LEN_MSB:LEN_LSB] == '0) ? LOAD_PARITY : LOAD_DATA;
            end
            LOAD_DATA: begin
                busy = fifo_full[addr];
                if (pkt_valid && !fifo_full[addr]) begin
                    write_enb = 3'b001 << addr;
                    dout      = data_in;
                    if (remaining == LEN_W'(1))
                        state_nxt = LOAD_PARITY;
                end
            end
            LOAD_PARITY: begin
                busy = fifo_full[addr];
                if (pkt_valid && !fifo_full[addr]) begin
                    write_enb = 3'b001 << addr;
                    dout      = data_in;
`ifdef ROUTER_PARITY_CHK_EN
                    state_nxt = CHECK_PARITY;
`else
                    state_nxt = DECODE;
`endif
                end
            end
`ifdef ROUTER_PARITY_CHK_EN
            CHECK_PARITY: begin
                busy      = 1'b1;
                state_nxt = DECODE;
            end
`endif
            default: state_nxt = DECODE;
        endcase
        // Watchdog on the active port abandons the packet; source must resync
        if (abort) begin
            state_nxt = DECODE;
            busy      = 1'b1;
            write_enb = '0;
            dout      = '0;
            lfd_state = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge rst_sync) begin
        if (!rst_sync) begin
            state     <= DECODE;
            header    <= '0;
            addr      <= '0;
            remaining <= '0;
        end else begin
            state <= state_nxt;
            if (hdr_take) begin
                header <= data_in;
                addr   <= data_in[ADDR_MSB:ADDR_LSB];
            end
            if (state == LOAD_FIRST)
                remaining <= header[LEN_MSB:LEN_LSB];
            else if (pay_take)
                remaining <= remaining - 1'b1;
        end
    end

`ifdef ROUTER_PARITY_CHK_EN
    logic [7:0] parity, rx_parity;

    always_ff @(posedge clock or negedge rst_sync) begin
        if (!rst_sync) begin
            parity    <= '0;
            rx_parity <= '0;
            err       <= 1'b0;
        end else begin
            if (hdr_take) begin
                parity <= data_in;
                err    <= 1'b0;
            end else if (pay_take) begin
                parity <= parity ^ data_in;
            end
            if (state == LOAD_PARITY && accept)
                rx_parity <= data_in;
            if (state == CHECK_PARITY)
                err <= (parity != rx_parity);
        end
    end
`else
    assign err = 1'b0;
`endif

    for (genvar i = 0; i < 3; i++) begin : g_timer
        router_sync_timer #(.TIMEOUT(TIMEOUT)) u_timer (
            .clock      (clock),
            .resetn     (rst_sync),
            .vld        (vld_out[i]),
            .read_enb   (read_enb[i]),
            .soft_reset (soft_reset[i])
        );
    end

endmodule

// File: doc/router_ctrl.md
ROUTER_CTRL -- requirements
Module: router_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 30, consecutive un-read cycles on a valid output before that port's soft reset fires.
REQ-002 clock  input  1  single clock; all state on rising edge.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 pkt_valid  input  1  source has a byte on data_in.
REQ-005 data_in  input  8  packet byte; in header, [1:0] = destination port, [7:2] = payload length.
REQ-006 fifo_full  input  3  per-port FIFO full.
REQ-007 fifo_empty  input  3  per-port FIFO empty.
REQ-008 read_enb  input  3  per-port downstream read strobe.
REQ-009 busy  output  1  byte on data_in not accepted this cycle; source holds it.
REQ-010 write_enb  output  3  one-hot FIFO write strobe.
REQ-011 dout  output  8  byte to FIFOs.
REQ-012 lfd_state  output  1  marks header write.
REQ-013 vld_out  output  3  = ~fifo_empty.
REQ-014 soft_reset  output  3  per-port one-cycle soft reset pulse.
REQ-015 err  output  1  parity mismatch on last packet.

Function
REQ-016 States: DECODE, WAIT_TILL_EMPTY, LOAD_FIRST, LOAD_DATA, LOAD_PARITY, CHECK_PARITY.
REQ-017 Byte accepted iff pkt_valid && !busy; at most one write_enb bit high, only on an accepted byte or in LOAD_FIRST.
REQ-018 DECODE: busy=0; pkt_valid with addr!=3: latch header and addr, clear err, parity<=header; fifo_empty[addr] -> LOAD_FIRST, else -> WAIT_TILL_EMPTY. addr==3: byte dropped, stay.
REQ-019 WAIT_TILL_EMPTY: busy=1; fifo_empty[addr] -> LOAD_FIRST.
REQ-020 LOAD_FIRST: busy=1, lfd_state=1, dout=header, write_enb[addr]=1; remaining<=length; length 0 -> LOAD_PARITY, else LOAD_DATA.
REQ-021 LOAD_DATA: busy=fifo_full[addr]; accepted byte written (dout=data_in), parity^=byte, remaining-1; last payload byte -> LOAD_PARITY.
REQ-022 LOAD_PARITY: busy=fifo_full[addr]; accepted byte written, latched as rx_parity -> CHECK_PARITY.
REQ-023 CHECK_PARITY: busy=1; err<=(parity!=rx_parity); -> DECODE. err holds until next header accepted.
REQ-024 Full FIFO never written; fifo_full rising mid-packet stalls via busy with zero data loss.
REQ-025 Timer per port: counts cycles with vld_out[i] && !read_enb[i]; cleared on read_enb[i] or !vld_out[i]; at TIMEOUT, soft_reset[i]=1 one cycle, counter cleared.
REQ-026 soft_reset[addr] while in WAIT_TILL_EMPTY/LOAD_*: next state DECODE, no further writes, err unchanged; source resynchronisation is source's duty.
REQ-027 Latency: header to FIFO write min 2 cycles; payload/parity written same cycle accepted.

Reset
REQ-028 resetn low: state DECODE; busy, write_enb, lfd_state, soft_reset, err, dout, counters, parity = 0; asynchronous assert, synchronous release.

Configuration
REQ-029 ROUTER_PARITY_CHK_EN defined: REQ-023 as written. Undefined: err tied 0, LOAD_PARITY -> DECODE directly, CHECK_PARITY and parity regs absent; parity byte still written.

Structure
REQ-030 router_pkg holds state encoding, INVALID_ADDR=2'b11, default TIMEOUT, length field bit positions.
REQ-031 One sub-module router_sync_timer (per-port timeout counter), instantiated 3x.

Verification
REQ-032 Header 8'h0D (port1, len3), payload 11,22,33, parity 0D^11^22^33 -> 5 writes to port1, lfd on first, err=0.
REQ-033 Same packet, parity byte 8'h00 -> err=1 after CHECK_PARITY; cleared by next header.
REQ-034 Header to port2 while fifo_empty[2]=0 -> busy=1 in WAIT_TILL_EMPTY, header written cycle after fifo_empty[2] rises.
REQ-035 fifo_full[0] asserted mid-payload 4 cycles -> busy=1, write_enb[0]=0 for 4 cycles, no byte lost.
REQ-036 vld_out[1]=1, read_enb[1]=0 for 30 cycles -> soft_reset[1] pulses once at cycle 30; read at cycle 29 -> no pulse.
REQ-037 Header 8'h07 (addr 3) -> no write, stay DECODE; resetn low mid-LOAD_DATA -> all outputs 0 immediately.
